// File: rtl/oam_dma_engine_if.sv
// Handshake and bus-strobe bundle between the OAM DMA engine and the memory/arbiter side.
// The shared tri-state databus is kept as a plain inout port on the engine itself.
interface oam_dma_engine_if;
    logic        dma_start;
    logic [7:0]  dma_src;
    logic        bus_gnt;
    logic        bus_req;
    logic [15:0] address;
    logic        OE;
    logic        WE;
    logic        busy;
    logic        done;

    modport master (
        input  dma_start, dma_src, bus_gnt,
        output bus_req, address, OE, WE, busy, done
    );

    modport slave (
        output dma_start, dma_src, bus_gnt,
        input  bus_req, address, OE, WE, busy, done
    );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: on a 0xFF46 write, copies XFER_LEN bytes from {src,00} into OAM,
// one read and one write cycle per byte, stalling whenever the bus grant is withdrawn.
module oam_dma_engine #(
    parameter int unsigned XFER_LEN = 160,
    parameter logic [15:0] DST_BASE = 16'hFE00
) (
    input  logic             clk,
    input  logic             rst,
    oam_dma_engine_if.master bus,
    inout  wire  [7:0]       databus
);

    localparam int unsigned IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;

    if (XFER_LEN == 0 || XFER_LEN > 256) begin : g_len_check
        $error("oam_dma_engine: XFER_LEN must be in 1..256");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         src_q, src_d;
    logic [7:0]         latch_q, latch_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [15:0]        addr_q, addr_d;
    logic               owns_c;

    // Next-state, index/source/latch updates and the registered phase decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        latch_d = latch_q;

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (bus.dma_start) begin
                    src_d   = bus.dma_src;
                    idx_d   = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) state_d = S_READ;
            end
            S_READ: begin
                if (bus.bus_gnt) begin
                    latch_d = databus;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.bus_gnt) begin
                    if (idx_q == IDX_W'(XFER_LEN - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new 0xFF46 write mid-transfer restarts from byte 0 without dropping the request.
        if (bus.dma_start && (state_q == S_REQ || state_q == S_READ || state_q == S_WRITE)) begin
            src_d   = bus.dma_src;
            idx_d   = '0;
            state_d = S_REQ;
        end

        req_d  = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WRITE);
        busy_d = req_d;
        done_d = (state_d == S_FINISH);
        rd_d   = (state_d == S_READ);
        wr_d   = (state_d == S_WRITE);
        addr_d = 16'h0000;
        if (rd_d)      addr_d = {src_d, 8'(idx_d)};
        else if (wr_d) addr_d = DST_BASE + 16'(idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            src_q   <= 8'h00;
            latch_q <= 8'h00;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            latch_q <= latch_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
        end
    end

    // Bus-facing strobes are zero without grant so they can be OR-muxed with the CPU.
    assign owns_c      = bus.bus_gnt & ~rst;
    assign bus.bus_req = req_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.address = owns_c ? addr_q : 16'h0000;
    assign bus.OE      = owns_c & rd_q;
    assign bus.WE      = owns_c & wr_q;
    assign databus     = (owns_c & wr_q) ? latch_q : 8'hzz;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Randomized bench for oam_dma_engine: a memory model on the shared bus plus a
// step-counting reference that predicts the write stream, done cycle and busy span.
module tb_oam_dma_engine;

    localparam int MAXC = 2000;

    logic       clk;
    logic       rst;
    wire  [7:0] databus;

    oam_dma_engine_if bus_if ();

    oam_dma_engine dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .databus (databus)
    );

    logic [7:0]  mem [65536];
    logic [23:0] wlog [$];
    bit          g [MAXC];
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory unit: answers reads combinationally, commits writes at the clock edge.
    assign databus = bus_if.OE ? mem[bus_if.address] : 8'hzz;

    always @(posedge clk) begin
        if (bus_if.WE) begin
            mem[bus_if.address] = databus;
            wlog.push_back({bus_if.address, databus});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oam_diff(input logic [7:0] src, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i < hi; i++)
            if (mem[16'hFE00 + 16'(i)] !== mem[{src, 8'(i)}]) n++;
        return n;
    endfunction

    // Reference: every granted cycle advances one step (REQ, READ0, WRITE0, READ1, ...);
    // a start pulse resets the step count after that cycle's action; done follows step 321.
    task automatic run_xfer(input string tag, input logic [7:0] src0, input int restart_at,
                            input logic [7:0] src1, input int gap_at, input int gap_len,
                            input int gnt_pct);
        logic [23:0] exp_w [$];
        logic [7:0]  src;
        int n, k, done_exp, done_at, done_cnt, busy_cnt, viol, wr_err;

        for (int c = 0; c < MAXC; c++)
            g[c] = (c >= gap_at && c < gap_at + gap_len) ? 1'b0 : ($urandom_range(99) < gnt_pct);

        n = 0; src = src0; done_exp = -1;
        for (int c = 1; c < MAXC && done_exp < 0; c++) begin
            if (g[c]) begin
                n++;
                if (n >= 3 && (n % 2) == 1) begin
                    k = (n - 3) / 2;
                    exp_w.push_back({16'hFE00 + 16'(k), mem[{src, 8'(k)}]});
                end
                if (n == 321) done_exp = c + 1;
            end
            if (c == restart_at) begin
                n = 0;
                src = src1;
            end
        end

        wlog.delete();
        bus_if.bus_gnt   = g[0];
        bus_if.dma_src   = src0;
        bus_if.dma_start = 1'b1;
        tick();
        bus_if.dma_start = 1'b0;
        done_cnt = 0; busy_cnt = 0; viol = 0; done_at = -1;
        for (int c = 1; c < done_exp + 6 && c < MAXC; c++) begin
            bus_if.bus_gnt = g[c];
            if (c == restart_at) begin
                bus_if.dma_start = 1'b1;
                bus_if.dma_src   = src1;
            end
            @(negedge clk);
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin
                done_cnt++;
                done_at = c;
            end
            if (!bus_if.bus_gnt && (bus_if.OE || bus_if.WE || bus_if.address != 16'h0000)) viol++;
            if (bus_if.OE && bus_if.WE) viol++;
            if (bus_if.busy != bus_if.bus_req) viol++;
            tick();
            bus_if.dma_start = 1'b0;
        end
        bus_if.bus_gnt = 1'b0;

        wr_err = 0;
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
            if (wlog[i] !== exp_w[i]) wr_err++;

        chk({tag, "_done_at"},   32'(done_at),     32'(done_exp));
        chk({tag, "_done_cnt"},  32'(done_cnt),    32'd1);
        chk({tag, "_busy_cyc"},  32'(busy_cnt),    32'(done_exp - 1));
        chk({tag, "_bus_rules"}, 32'(viol),        32'd0);
        chk({tag, "_wr_count"},  32'(wlog.size()), 32'(exp_w.size()));
        chk({tag, "_wr_stream"}, 32'(wr_err),      32'd0);
        chk({tag, "_oam"},       32'(oam_diff(restart_at >= 0 ? src1 : src0, 0, 160)), 32'd0);
    endtask

    initial begin
        int viol, done_cnt;
        logic [7:0] rsrc;

        total = 0;
        bad   = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        bus_if.dma_start = 1'b0;
        bus_if.dma_src   = 8'h00;
        bus_if.bus_gnt   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_outputs", 32'({bus_if.bus_req, bus_if.OE, bus_if.WE, bus_if.busy, bus_if.done}), 32'd0);
        chk("rst_address", 32'(bus_if.address), 32'd0);
        rst = 1'b0;
        tick();

        // Idle isolation with a toggling grant.
        wlog.delete();
        viol = 0;
        for (int c = 0; c < 100; c++) begin
            bus_if.bus_gnt = 1'($urandom);
            @(negedge clk);
            if (bus_if.bus_req || bus_if.OE || bus_if.WE || bus_if.busy || bus_if.done ||
                bus_if.address != 16'h0000) viol++;
            tick();
        end
        bus_if.bus_gnt = 1'b0;
        chk("idle_quiet",  32'(viol),        32'd0);
        chk("idle_writes", 32'(wlog.size()), 32'd0);

        for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        run_xfer("basic", 8'hC0, -1, 8'h00, MAXC, 0, 100);
        run_xfer("late_gnt", 8'hC4, -1, 8'h00, 1, 10, 100);
        run_xfer("gnt_drop", 8'hC5, -1, 8'h00, 77, 5, 100);
        run_xfer("restart", 8'hC0, 102, 8'hC1, MAXC, 0, 100);
        rsrc = 8'($urandom_range(8'hDF, 8'hC6));
        run_xfer("rand_gnt", rsrc, -1, 8'h00, MAXC, 0, 70);
        rsrc = 8'($urandom_range(8'hDF, 8'hC6));
        run_xfer("rand_restart", 8'hC3, 40 + $urandom_range(200), rsrc, MAXC, 0, 80);

        // Reset during the READ of byte 80: prior OAM above 0xFE50 must survive.
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'(i) ^ 8'hA5;
        bus_if.bus_gnt   = 1'b1;
        bus_if.dma_src   = 8'hC2;
        bus_if.dma_start = 1'b1;
        tick();
        bus_if.dma_start = 1'b0;
        for (int c = 1; c < 162; c++) tick();
        @(negedge clk);
        chk("rst_pre_addr", 32'(bus_if.address), 32'h0000C250);
        chk("rst_pre_oe",   32'(bus_if.OE),      32'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_mid_outputs", 32'({bus_if.bus_req, bus_if.OE, bus_if.WE, bus_if.busy, bus_if.done}), 32'd0);
        chk("rst_mid_address", 32'(bus_if.address), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            if (bus_if.done || bus_if.busy) done_cnt++;
        end
        bus_if.bus_gnt = 1'b0;
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_low_oam", 32'(oam_diff(8'hC2, 0, 80)), 32'd0);
        viol = 0;
        for (int i = 80; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) viol++;
        chk("rst_high_oam", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
